complex_dot_product_n: RTL and testbench
========================================

COMPLEX_DOT_PRODUCT_N -- requirements
Module: complex_dot_product_n

Interface
REQ-001 The block SHALL have parameter Width, default 8, meaning the signed two's-complement width of each real or imaginary input and output component.
REQ-002 The block SHALL have parameter N, default 4, meaning the vector length (row elements times column elements), with N >= 1.
REQ-003 CLK  input  1  the single clock; all state changes on the rising edge.
REQ-004 MasterReset  input  1  asynchronous, active-high reset.
REQ-005 Enable  input  1  global advance; when low, all state freezes.
REQ-006 Start  input  1  request to capture operands and begin the computation.
REQ-007 RowReal, RowImag  input  N*Width  row vector A; element k occupies bits [k*Width +: Width].
REQ-008 ColReal, ColImag  input  N*Width  column vector B, same packing as the row vector.
REQ-009 OutReal, OutImag  output  Width  registered, saturated result of sum(A[k]*B[k]).
REQ-010 Busy  output  1  high from the capture cycle until Listo.
REQ-011 Listo  output  1  one-cycle done pulse; OutReal and OutImag are valid from this cycle.
REQ-012 Error  output  1  overflow flag; high if either result component was saturated.

Function
REQ-013 The block SHALL use the FSM states IDLE, MAC and DONE.
REQ-014 In IDLE with Enable=1 and Start=1, the block SHALL capture all four operand vectors into internal registers, clear the accumulators and Error, and go to MAC.
REQ-015 MAC SHALL run 4N steps with one signed Width x Width multiplier, stepping per element k=0..N-1 in this order:
- accR += Ar*Br
- accR -= Ai*Bi
- accI += Ar*Bi
- accI += Ai*Br
REQ-016 The accumulators SHALL be 2*Width+clog2(N)+1 bits wide, so that no intermediate overflow occurs.
REQ-017 After the last step the FSM SHALL enter DONE, in which it registers OutReal/OutImag, pulses Listo, drops Busy, and returns to IDLE.
REQ-018 Each output component SHALL saturate to [-2^(Width-1), 2^(Width-1)-1].
REQ-019 Error SHALL be set in DONE if either component saturated, and SHALL hold until the next accepted Start or reset.
REQ-020 Latency SHALL be exactly 4N+1 enabled edges from the Start-capturing edge to the edge that asserts Listo (17 for N=4).
REQ-021 With Enable=0, the FSM, step counter, accumulators and outputs SHALL hold, and Listo SHALL stay asserted if it was high.
REQ-022 Start SHALL be ignored while Busy=1, and operand changes after capture SHALL have no effect.
REQ-023 Start high in the DONE cycle SHALL be ignored; Start high in the following IDLE cycle SHALL be accepted, giving back-to-back throughput of one result per 4N+2 cycles.
REQ-024 OutReal, OutImag and Error SHALL hold their last values in IDLE until the next DONE.

Reset
REQ-025 On MasterReset the block SHALL immediately enter IDLE, with zero in the step counter, accumulators, OutReal, OutImag, Busy, Listo and Error.
REQ-026 A reset during MAC SHALL abort the computation with no Listo pulse, and the next Start SHALL run normally.

Structure
REQ-027 A shared include file SHALL hold the FSM state encodings and the accumulator-width and saturation-limit constant functions.
REQ-028 The multiply-accumulate datapath (multiplier, add/subtract select, two accumulators, saturation) SHALL be one sub-module, complex_mac_unit, controlled by the FSM.

Verification
REQ-029 Width=8, N=4, all A=1+1j, all B=2+0j -> OutReal=8, OutImag=8, Error=0, Listo on edge 17.
REQ-030 A0=3+2j, B0=1+4j, all other elements 0 -> OutReal=-5, OutImag=14.
REQ-031 All A=100+0j, B=100+0j -> OutReal=127, OutImag=0, Error=1; then A0=127+0j, B0=-128+0j, other elements 0 -> OutReal=-128, Error=1.
REQ-032 Case REQ-029 with Enable low for 5 cycles mid-MAC -> same result, Listo on edge 22.
REQ-033 MasterReset pulsed at MAC step 6 -> all outputs 0 at once, no Listo; a following Start returns the correct result.
REQ-034 Start re-pulsed with different operands while Busy -> ignored; result matches the first operands.

Source files
------------

// File: rtl/complex_dot_product_n_pkg.sv
// Shared definitions for the complex dot-product block: FSM encoding, MAC step
// selection and the width/limit helpers used to size the datapath.
package complex_dot_product_n_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Four multiply steps per element, in the order the accumulators are updated.
    typedef enum logic [1:0] {
        OP_RR = 2'd0,   // acc_r += ar*br
        OP_II = 2'd1,   // acc_r -= ai*bi
        OP_RI = 2'd2,   // acc_i += ar*bi
        OP_IR = 2'd3    // acc_i += ai*br
    } op_t;

    function automatic int acc_width(input int width, input int n);
        return 2 * width + $clog2(n) + 1;
    endfunction

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/complex_mac_unit.sv
// Shared-multiplier complex MAC: one signed product per step, two wide
// accumulators, and saturating output registers with an overflow flag.
module complex_mac_unit
    import complex_dot_product_n_pkg::*;
#(
    parameter int Width = 8,
    parameter int N     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clear,
    input  logic                    step_en,
    input  logic                    out_load,
    input  op_t                     op,
    input  logic signed [Width-1:0] ar,
    input  logic signed [Width-1:0] ai,
    input  logic signed [Width-1:0] br,
    input  logic signed [Width-1:0] bi,
    output logic signed [Width-1:0] out_real,
    output logic signed [Width-1:0] out_imag,
    output logic                    error
);

    localparam int AccW = acc_width(Width, N);
    localparam logic signed [AccW-1:0] SatMax = AccW'(sat_max(Width));
    localparam logic signed [AccW-1:0] SatMin = AccW'(sat_min(Width));

    logic signed [Width-1:0]   mul_a, mul_b;
    logic signed [2*Width-1:0] prod;
    logic signed [AccW-1:0]    prod_ext, acc_r, acc_i;
    logic [Width:0]            sat_r, sat_i;

    // Returns {overflow, clamped value}.
    function automatic logic [Width:0] saturate(input logic signed [AccW-1:0] v);
        if (v > SatMax)      return {1'b1, SatMax[Width-1:0]};
        else if (v < SatMin) return {1'b1, SatMin[Width-1:0]};
        else                 return {1'b0, v[Width-1:0]};
    endfunction

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        mul_a = ar;
        mul_b = br;
        case (op)
            OP_II:   begin mul_a = ai; mul_b = bi; end
            OP_RI:   mul_b = bi;
            OP_IR:   mul_a = ai;
            default: ;
        endcase
    end

    assign prod     = mul_a * mul_b;
    assign prod_ext = AccW'(prod);
    assign sat_r    = saturate(acc_r);
    assign sat_i    = saturate(acc_i);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r    <= '0;
            acc_i    <= '0;
            out_real <= '0;
            out_imag <= '0;
            error    <= 1'b0;
        end else if (en) begin
            if (clear) begin
                acc_r <= '0;
                acc_i <= '0;
                error <= 1'b0;
            end else if (step_en) begin
                case (op)
                    OP_RR:   acc_r <= acc_r + prod_ext;
                    OP_II:   acc_r <= acc_r - prod_ext;
                    default: acc_i <= acc_i + prod_ext;
                endcase
            end
            if (out_load) begin
                out_real <= sat_r[Width-1:0];
                out_imag <= sat_i[Width-1:0];
                error    <= sat_r[Width] | sat_i[Width];
            end
        end
    end

endmodule

// File: rtl/complex_dot_product_n.sv
// Sequential complex dot product sum(A[k]*B[k]) over N elements, computed in
// 4N multiply steps on a single shared multiplier, with saturated outputs.
module complex_dot_product_n
    import complex_dot_product_n_pkg::*;
#(
    parameter int Width = 8,
    parameter int N     = 4
) (
    input  logic                 CLK,
    input  logic                 MasterReset,
    input  logic                 Enable,
    input  logic                 Start,
    input  logic [N*Width-1:0]   RowReal,
    input  logic [N*Width-1:0]   RowImag,
    input  logic [N*Width-1:0]   ColReal,
    input  logic [N*Width-1:0]   ColImag,
    output logic [Width-1:0]     OutReal,
    output logic [Width-1:0]     OutImag,
    output logic                 Busy,
    output logic                 Listo,
    output logic                 Error
);

    localparam int IdxW = (N > 1) ? $clog2(N) : 1;

    state_t             state, state_next;
    op_t                op_q;
    logic [IdxW-1:0]    elem_q;
    logic               accept, step_en, out_load, last_step;
    logic [N*Width-1:0] row_real_q, row_imag_q, col_real_q, col_imag_q;
    logic signed [Width-1:0] ar, ai, br, bi;

    assign last_step = (op_q == OP_IR) && (elem_q == IdxW'(N - 1));

    always_ff @(posedge CLK or posedge MasterReset) begin
        if (MasterReset)  state <= IDLE;
        else if (Enable)  state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = MAC;
            MAC:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept   = 1'b0;
        step_en  = 1'b0;
        out_load = 1'b0;
        case (state)
            IDLE:    accept   = Start;
            MAC:     step_en  = 1'b1;
            DONE:    out_load = 1'b1;
            default: ;
        endcase
    end

    // Step counter is {element, op}; Busy spans capture through the DONE edge.
    always_ff @(posedge CLK or posedge MasterReset) begin
        if (MasterReset) begin
            op_q   <= OP_RR;
            elem_q <= '0;
            Busy   <= 1'b0;
            Listo  <= 1'b0;
        end else if (Enable) begin
            Listo <= out_load;
            if (accept) begin
                op_q   <= OP_RR;
                elem_q <= '0;
                Busy   <= 1'b1;
            end else if (step_en) begin
                op_q <= op_t'(op_q + 2'd1);
                if (last_step)           elem_q <= '0;
                else if (op_q == OP_IR)  elem_q <= elem_q + 1'b1;
            end else if (out_load) begin
                Busy <= 1'b0;
            end
        end
    end

    // NOTE: operand registers are not reset; they are always loaded on capture before use.
    always_ff @(posedge CLK) begin
        if (Enable && accept) begin
            row_real_q <= RowReal;
            row_imag_q <= RowImag;
            col_real_q <= ColReal;
            col_imag_q <= ColImag;
        end
    end

    assign ar = row_real_q[int'(elem_q)*Width +: Width];
    assign ai = row_imag_q[int'(elem_q)*Width +: Width];
    assign br = col_real_q[int'(elem_q)*Width +: Width];
    assign bi = col_imag_q[int'(elem_q)*Width +: Width];

    complex_mac_unit #(.Width(Width), .N(N)) u_mac (
        .clk      (CLK),
        .rst      (MasterReset),
        .en       (Enable),
        .clear    (accept),
        .step_en  (step_en),
        .out_load (out_load),
        .op       (op_q),
        .ar       (ar),
        .ai       (ai),
        .br       (br),
        .bi       (bi),
        .out_real (OutReal),
        .out_imag (OutImag),
        .error    (Error)
    );

endmodule

// File: tb/tb_complex_dot_product_n.sv
// Scoreboard bench for complex_dot_product_n (Width=8, N=4): directed vectors,
// expected results queued at issue time and compared on each Listo pulse.
module tb_complex_dot_product_n;

    localparam int W = 8;
    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           MasterReset, Enable, Start;
    logic [N*W-1:0] RowReal, RowImag, ColReal, ColImag;
    logic [W-1:0]   OutReal, OutImag;
    logic           Busy, Listo, Error;

    complex_dot_product_n #(.Width(W), .N(N)) dut (
        .CLK         (CLK),
        .MasterReset (MasterReset),
        .Enable      (Enable),
        .Start       (Start),
        .RowReal     (RowReal),
        .RowImag     (RowImag),
        .ColReal     (ColReal),
        .ColImag     (ColImag),
        .OutReal     (OutReal),
        .OutImag     (OutImag),
        .Busy        (Busy),
        .Listo       (Listo),
        .Error       (Error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int re;
        int im;
        bit err;
        int start;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   listo_cyc = 0;
    logic listo_d  = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N*W-1:0] pk(input int e0, input int e1, input int e2, input int e3);
        logic [N*W-1:0] v;
        v[0*W +: W] = W'(e0);
        v[1*W +: W] = W'(e1);
        v[2*W +: W] = W'(e2);
        v[3*W +: W] = W'(e3);
        return v;
    endfunction

    // Monitor: compare each rising Listo against the oldest queued expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (Listo && !listo_d) begin
            listo_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_listo", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_real", int'($signed(OutReal)), e.re);
                check("out_imag", int'($signed(OutImag)), e.im);
                check("error",    int'(Error), int'(e.err));
                check("latency",  cyc - e.start, e.lat);
                check("busy_at_listo", int'(Busy), 0);
            end
        end
        listo_d = Listo;
    end

    // Called at a negedge; drives one Start pulse, returns the capture cycle.
    task automatic issue(input logic [N*W-1:0] rr, input logic [N*W-1:0] ri,
                         input logic [N*W-1:0] cr, input logic [N*W-1:0] ci,
                         input int re, input int im, input bit err, input int lat,
                         input bit track, output int start_c);
        exp_t e;
        RowReal = rr; RowImag = ri; ColReal = cr; ColImag = ci;
        Start = 1'b1;
        @(posedge CLK);
        #1;
        start_c = cyc;
        if (track) begin
            e.re = re; e.im = im; e.err = err; e.start = cyc; e.lat = lat;
            sb.push_back(e);
        end
        @(negedge CLK);
        Start = 1'b0;
        check("busy_after_start", int'(Busy), 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(posedge CLK);
        end
        check("drain", sb.size(), 0);
        if (sb.size() != 0) sb.delete();
        @(negedge CLK);
    endtask

    logic [N*W-1:0] t1_rr, t1_ri, t1_cr, t1_ci;
    logic [N*W-1:0] t2_rr, t2_ri, t2_cr, t2_ci;

    initial begin
        int sc;
        bit seen;
        t1_rr = pk(1, 1, 1, 1); t1_ri = pk(1, 1, 1, 1);
        t1_cr = pk(2, 2, 2, 2); t1_ci = pk(0, 0, 0, 0);
        t2_rr = pk(3, 0, 0, 0); t2_ri = pk(2, 0, 0, 0);
        t2_cr = pk(1, 0, 0, 0); t2_ci = pk(4, 0, 0, 0);

        MasterReset = 1'b1; Enable = 1'b1; Start = 1'b0;
        RowReal = '0; RowImag = '0; ColReal = '0; ColImag = '0;
        #1;
        check("rst_out_real", int'(OutReal), 0);
        check("rst_out_imag", int'(OutImag), 0);
        check("rst_busy",     int'(Busy),    0);
        check("rst_listo",    int'(Listo),   0);
        check("rst_error",    int'(Error),   0);
        @(negedge CLK); @(negedge CLK);
        MasterReset = 1'b0;
        @(negedge CLK);

        // Basic: all A=1+1j, B=2+0j
        issue(t1_rr, t1_ri, t1_cr, t1_ci, 8, 8, 1'b0, 17, 1'b1, sc);
        wait_done();

        // Single non-zero element: (3+2j)(1+4j) = -5+14j
        issue(t2_rr, t2_ri, t2_cr, t2_ci, -5, 14, 1'b0, 17, 1'b1, sc);
        wait_done();

        // Positive saturation
        issue(pk(100, 100, 100, 100), pk(0, 0, 0, 0), pk(100, 100, 100, 100), pk(0, 0, 0, 0),
              127, 0, 1'b1, 17, 1'b1, sc);
        wait_done();
        repeat (3) @(negedge CLK);
        check("idle_hold_error", int'(Error), 1);
        check("idle_hold_real",  int'($signed(OutReal)), 127);

        // Negative saturation: 127 * -128
        issue(pk(127, 0, 0, 0), pk(0, 0, 0, 0), pk(-128, 0, 0, 0), pk(0, 0, 0, 0),
              -128, 0, 1'b1, 17, 1'b1, sc);
        wait_done();

        // Reset mid-MAC aborts: outputs clear at once, no Listo
        issue(t1_rr, t1_ri, t1_cr, t1_ci, 0, 0, 1'b0, 0, 1'b0, sc);
        repeat (5) @(negedge CLK);
        #3 MasterReset = 1'b1;
        #1;
        check("abort_out_real", int'(OutReal), 0);
        check("abort_out_imag", int'(OutImag), 0);
        check("abort_busy",     int'(Busy),    0);
        check("abort_error",    int'(Error),   0);
        @(negedge CLK);
        MasterReset = 1'b0;
        repeat (25) @(negedge CLK);
        issue(t1_rr, t1_ri, t1_cr, t1_ci, 8, 8, 1'b0, 17, 1'b1, sc);
        wait_done();

        // Enable low for 5 cycles mid-MAC stretches latency to 22 edges
        issue(t1_rr, t1_ri, t1_cr, t1_ci, 8, 8, 1'b0, 22, 1'b1, sc);
        repeat (4) @(negedge CLK);
        Enable = 1'b0;
        repeat (5) @(negedge CLK);
        Enable = 1'b1;
        wait_done();

        // Back-to-back: next Start in the Listo cycle is accepted
        issue(t2_rr, t2_ri, t2_cr, t2_ci, -5, 14, 1'b0, 17, 1'b1, sc);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Listo) begin
                seen = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        check("b2b_listo_seen", int'(seen), 1);
        issue(t1_rr, t1_ri, t1_cr, t1_ci, 8, 8, 1'b0, 17, 1'b1, sc);
        check("b2b_capture_gap", sc - listo_cyc, 1);
        wait_done();

        // Start re-pulsed with new operands while busy is ignored
        issue(t1_rr, t1_ri, t1_cr, t1_ci, 8, 8, 1'b0, 17, 1'b1, sc);
        repeat (3) @(negedge CLK);
        RowReal = t2_rr; RowImag = t2_ri; ColReal = t2_cr; ColImag = t2_ci;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        wait_done();

        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
